// File: rtl/membus_arbiter_pkg.sv
// Shared types for the I/D memory bus arbiter.
// eei: bus widths; util: tag types; membus_arbiter_pkg: local helpers.
package eei;
   localparam int unsigned XLEN              = 64;
   localparam int unsigned ILEN              = 32;
   localparam int unsigned MEMBUS_DATA_WIDTH = 64;
endpackage

package util;
   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } ArbSrc;

   typedef struct packed {
      ArbSrc src;
      logic  wsel;
   } ArbTag;
endpackage

package membus_arbiter_pkg;
   import util::*;

   localparam int unsigned TAG_W = $bits(ArbTag);

   // Width of a counter that must hold 0..n inclusive.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction
endpackage

// File: rtl/membus_arbiter_if.sv
// Fetch, data and downstream bus bundle for membus_arbiter.
// slave: arbiter side; master: core/memory environment side.
interface membus_arbiter_if
   import eei::*;
#(
   parameter int unsigned XW = XLEN,
   parameter int unsigned IW = ILEN,
   parameter int unsigned DW = MEMBUS_DATA_WIDTH
) ();
   logic          i_valid;
   logic          i_ready;
   logic [XW-1:0] i_addr;
   logic          i_rvalid;
   logic [IW-1:0] i_rdata;

   logic            d_valid;
   logic            d_ready;
   logic [XW-1:0]   d_addr;
   logic            d_wen;
   logic [DW-1:0]   d_wdata;
   logic [DW/8-1:0] d_wmask;
   logic            d_rvalid;
   logic [DW-1:0]   d_rdata;

   logic            m_valid;
   logic            m_ready;
   logic [XW-1:0]   m_addr;
   logic            m_wen;
   logic [DW-1:0]   m_wdata;
   logic [DW/8-1:0] m_wmask;
   logic            m_rvalid;
   logic [DW-1:0]   m_rdata;

   modport slave (
      input  i_valid, i_addr,
      output i_ready, i_rvalid, i_rdata,
      input  d_valid, d_addr, d_wen, d_wdata, d_wmask,
      output d_ready, d_rvalid, d_rdata,
      output m_valid, m_addr, m_wen, m_wdata, m_wmask,
      input  m_ready, m_rvalid, m_rdata
   );

   modport master (
      output i_valid, i_addr,
      input  i_ready, i_rvalid, i_rdata,
      output d_valid, d_addr, d_wen, d_wdata, d_wmask,
      input  d_ready, d_rvalid, d_rdata,
      input  m_valid, m_addr, m_wen, m_wdata, m_wmask,
      output m_ready, m_rvalid, m_rdata
   );
endinterface

// File: rtl/membus_arbiter_tag_fifo.sv
// In-order tag FIFO: push/pop, full/empty, occupancy count.
// Ports: clk, rst (async low), push/din, pop/dout, full, empty, count.
module tag_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = nxt(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = nxt(rd_ptr_q);
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end
endmodule

// File: rtl/membus_arbiter.sv
// Arbitrates fetch and data requesters onto one downstream bus.
// Ports: clk, rst (async low), bus (slave), outstanding, proto_err.
module membus_arbiter
   import util::*;
   import membus_arbiter_pkg::*;
#(
   parameter int unsigned XLEN            = eei::XLEN,
   parameter int unsigned ILEN            = eei::ILEN,
   parameter int unsigned DATA_WIDTH      = eei::MEMBUS_DATA_WIDTH,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned STARVE_LIMIT    = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   membus_arbiter_if.slave                      bus,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
   output logic                                 proto_err
);
   localparam int unsigned SW = cnt_w(STARVE_LIMIT);

   logic [SW-1:0]    starve_q, starve_d;
   logic             proto_err_q, proto_err_d;
   logic             grant_i, grant_d;
   logic             full, empty;
   logic             issue, rsp_ok;
   ArbTag            push_tag, head_tag;
   logic [TAG_W-1:0] head_bits;

   // Fetch wins when data is idle or has had STARVE_LIMIT grants in a row.
   assign grant_i = bus.i_valid &&
                    (!bus.d_valid || starve_q == SW'(STARVE_LIMIT));
   assign grant_d = bus.d_valid && !grant_i;

   // full is from the registered count, so a same-cycle pop never frees
   // a slot; this keeps m_rvalid off the ready path.
   assign bus.m_valid = (bus.i_valid || bus.d_valid) && !full;
   assign bus.i_ready = bus.m_ready && !full && grant_i;
   assign bus.d_ready = bus.m_ready && !full && grant_d;
   assign issue       = bus.m_valid && bus.m_ready;

   assign bus.m_addr  = grant_i ? bus.i_addr : bus.d_addr;
   assign bus.m_wen   = grant_i ? 1'b0 : bus.d_wen;
   assign bus.m_wdata = grant_i ? '0 : bus.d_wdata;
   assign bus.m_wmask = grant_i ? '0 : bus.d_wmask;

   assign push_tag.src  = grant_i ? SRC_I : SRC_D;
   assign push_tag.wsel = bus.i_addr[2];

   assign head_tag = ArbTag'(head_bits);
   assign rsp_ok   = bus.m_rvalid && !empty;

   assign bus.i_rvalid = rsp_ok && (head_tag.src == SRC_I);
   assign bus.d_rvalid = rsp_ok && (head_tag.src == SRC_D);
   assign bus.i_rdata  = head_tag.wsel ?
                         bus.m_rdata[DATA_WIDTH-1 -: ILEN] :
                         bus.m_rdata[ILEN-1:0];
   assign bus.d_rdata  = bus.m_rdata;

   assign proto_err = proto_err_q;

   tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (TAG_W)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (issue),
      .din   (push_tag),
      .pop   (rsp_ok),
      .dout  (head_bits),
      .full  (full),
      .empty (empty),
      .count (outstanding)
   );

   always_comb begin
      starve_d    = starve_q;
      proto_err_d = proto_err_q || (bus.m_rvalid && empty);
      if (!bus.i_valid || (issue && grant_i)) begin
         starve_d = '0;
      end else if (issue && grant_d &&
                   starve_q != SW'(STARVE_LIMIT)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q    <= '0;
         proto_err_q <= 1'b0;
      end else begin
         starve_q    <= starve_d;
         proto_err_q <= proto_err_d;
      end
   end
endmodule
